// File: rtl/safe_pkg.sv
// Shared state encoding, code geometry and digit-select helper for the safe lock controller.
package safe_pkg;

  localparam int DIGIT_W  = 4;
  localparam int CODE_LEN = 4;
  localparam int CODE_W   = DIGIT_W * CODE_LEN;
  localparam int IDX_W    = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam logic [CODE_W-1:0] RESET_CODE = 16'hC3A5;

  typedef enum logic [2:0] {
    ST_LOCKED,
    ST_ENTRY,
    ST_CHECK,
    ST_UNLOCKED,
    ST_LOCKOUT,
    ST_PROGRAM
  } state_t;

  // Digit 0 is the most-significant digit, i.e. the first one keyed in.
  function automatic logic [DIGIT_W-1:0] code_digit(input logic [CODE_W-1:0] code,
                                                     input logic [IDX_W-1:0]  idx);
    return code[(CODE_LEN - 1 - int'(idx)) * DIGIT_W +: DIGIT_W];
  endfunction

endpackage

// File: rtl/safe_timer.sv
// Loadable up-counter with a terminal-count flag; shared by the lockout and auto-relock periods.
module safe_timer #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] term_val,
  output logic             tc
);

  logic [WIDTH-1:0] count_reg;

  // load returns the count to zero and takes priority over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign tc = (count_reg == term_val);

endmodule

// File: rtl/safe_lock_controller.sv
// Passcode compare controller: digit-by-digit check against a stored code, failed-attempt
// lockout, auto-relock timeout and code reprogramming while open.
module safe_lock_controller
  import safe_pkg::*;
#(
  parameter logic [CODE_W-1:0] DEFAULT_CODE   = RESET_CODE,
  parameter int                MAX_TRIES      = 3,
  parameter int                LOCKOUT_CYCLES = 1000,
  parameter int                UNLOCK_CYCLES  = 500
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               digit_valid,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               clear,
  input  logic               relock,
  input  logic               prog_en,
  output logic               unlocked,
  output logic               locked,
  output logic               lockout,
  output logic               fail_pulse,
  output logic [3:0]         attempts_left
);

  localparam int MAX_CYC = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
  localparam int TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CODE_LEN - 1);
  localparam logic [3:0]       MAX_FAILS = 4'(MAX_TRIES);

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic                mismatch_reg, mismatch_next;
  logic [3:0]          fail_cnt_reg, fail_cnt_next;
  logic [CODE_W-1:0]   code_reg, code_next;
  logic [CODE_W-1:0]   shadow_reg, shadow_next;
  logic [CODE_W-1:0]   shadow_shift;
  logic                unlocked_reg, lockout_reg, fail_pulse_reg;
  logic [3:0]          attempts_left_reg;
  logic                timer_load, timer_en, timer_tc;
  logic [TIMER_W-1:0]  timer_term;

  assign shadow_shift = {shadow_reg[CODE_W-DIGIT_W-1:0], digit};

  // Any state change restarts the timer, so each timed state always begins at zero.
  assign timer_load = (state_next != state_reg);
  assign timer_en   = (state_reg == ST_LOCKOUT) || (state_reg == ST_UNLOCKED);
  assign timer_term = (state_reg == ST_LOCKOUT) ? TIMER_W'(LOCKOUT_CYCLES - 1)
                                                : TIMER_W'(UNLOCK_CYCLES - 1);

  safe_timer #(.WIDTH(TIMER_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .en       (timer_en),
    .term_val (timer_term),
    .tc       (timer_tc)
  );

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    mismatch_next = mismatch_reg;
    fail_cnt_next = fail_cnt_reg;
    code_next     = code_reg;
    shadow_next   = shadow_reg;
    case (state_reg)
      ST_LOCKED, ST_ENTRY: begin
        if (clear) begin
          state_next    = ST_LOCKED;
          idx_next      = '0;
          mismatch_next = 1'b0;
        end else if (digit_valid) begin
          mismatch_next = mismatch_reg | (digit != code_digit(code_reg, idx_reg));
          if (idx_reg == LAST_IDX) begin
            state_next = ST_CHECK;
            idx_next   = '0;
          end else begin
            state_next = ST_ENTRY;
            idx_next   = idx_reg + 1'b1;
          end
        end
      end
      ST_CHECK: begin
        mismatch_next = 1'b0;
        if (!mismatch_reg) begin
          state_next    = ST_UNLOCKED;
          fail_cnt_next = '0;
        end else begin
          fail_cnt_next = (fail_cnt_reg >= MAX_FAILS) ? MAX_FAILS : fail_cnt_reg + 4'd1;
          state_next    = (fail_cnt_next == MAX_FAILS) ? ST_LOCKOUT : ST_LOCKED;
        end
      end
      ST_LOCKOUT: begin
        if (timer_tc) begin
          state_next    = ST_LOCKED;
          fail_cnt_next = '0;
        end
      end
      ST_UNLOCKED: begin
        if (relock || timer_tc) begin
          state_next = ST_LOCKED;
        end else if (digit_valid && prog_en) begin
          state_next  = ST_PROGRAM;
          shadow_next = shadow_shift;
          idx_next    = IDX_W'(1);
        end
      end
      ST_PROGRAM: begin
        if (relock) begin
          state_next = ST_LOCKED;
          idx_next   = '0;
        end else if (clear) begin
          state_next = ST_UNLOCKED;
          idx_next   = '0;
        end else if (digit_valid) begin
          shadow_next = shadow_shift;
          if (idx_reg == LAST_IDX) begin
            code_next  = shadow_shift;
            state_next = ST_UNLOCKED;
            idx_next   = '0;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      default: state_next = ST_LOCKED;
    endcase
  end

  // Outputs are decoded from the current state and therefore trail it by one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= ST_LOCKED;
      idx_reg           <= '0;
      mismatch_reg      <= 1'b0;
      fail_cnt_reg      <= '0;
      code_reg          <= DEFAULT_CODE;
      shadow_reg        <= '0;
      unlocked_reg      <= 1'b0;
      lockout_reg       <= 1'b0;
      fail_pulse_reg    <= 1'b0;
      attempts_left_reg <= MAX_FAILS;
    end else begin
      state_reg         <= state_next;
      idx_reg           <= idx_next;
      mismatch_reg      <= mismatch_next;
      fail_cnt_reg      <= fail_cnt_next;
      code_reg          <= code_next;
      shadow_reg        <= shadow_next;
      unlocked_reg      <= (state_reg == ST_UNLOCKED) || (state_reg == ST_PROGRAM);
      lockout_reg       <= (state_reg == ST_LOCKOUT);
      fail_pulse_reg    <= (state_reg == ST_CHECK) && mismatch_reg;
      attempts_left_reg <= MAX_FAILS - fail_cnt_next;
    end
  end

  assign unlocked      = unlocked_reg;
  assign locked        = ~unlocked_reg;
  assign lockout       = lockout_reg;
  assign fail_pulse    = fail_pulse_reg;
  assign attempts_left = attempts_left_reg;

endmodule

// File: doc/safe_lock_controller.md
Name: safe_lock_controller

Overview:
- Sequential controller for the safe's passcode compare datapath. Accepts a keypad digit stream one 4-bit digit per strobe and compares each digit in turn against a stored multi-digit code.
- Drives the unlock and lock indicators, counts failed attempts, enforces a lockout period, auto-relocks after a timeout, and allows the code to be reprogrammed while unlocked.
- Sits between the keypad/switch front end and the lock actuator/LED outputs.

Parameters:
- DIGIT_W, 4, bits per digit.
- CODE_LEN, 4, digits per code.
- DEFAULT_CODE, 16'hC3A5, code loaded on reset; first digit entered is the most-significant digit.
- MAX_TRIES, 3, consecutive failures that trigger lockout (range 1..15).
- LOCKOUT_CYCLES, 1000, clock cycles spent in LOCKOUT.
- UNLOCK_CYCLES, 500, clock cycles before UNLOCKED auto-relocks.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- digit_valid  in  1  one-cycle strobe; digit is valid.
- digit  in  DIGIT_W  keypad digit.
- clear  in  1  abort the current entry.
- relock  in  1  force relock from UNLOCKED.
- prog_en  in  1  level; while UNLOCKED, the next digit strobe enters PROGRAM.
- unlocked  out  1  safe open (L0 role).
- locked  out  1  always the inverse of unlocked (L1 role).
- lockout  out  1  high while in LOCKOUT.
- fail_pulse  out  1  one-cycle pulse on each failed attempt.
- attempts_left  out  4  equals MAX_TRIES minus fail_cnt.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - State LOCKED.
  - unlocked=0, locked=1, lockout=0, fail_pulse=0.
  - attempts_left=MAX_TRIES.
  - code_reg=DEFAULT_CODE; idx=0, mismatch=0, timer=0.
- All outputs are registered and decoded from the state (Moore). fail_pulse is registered.
- States:
  - LOCKED (idle)
  - ENTRY
  - CHECK
  - UNLOCKED
  - LOCKOUT
  - PROGRAM
- LOCKED/ENTRY:
  - A digit_valid strobe sets mismatch |= (digit != code_reg digit[idx]) and increments idx. The first strobe in LOCKED moves to ENTRY.
  - When the strobe accepts digit CODE_LEN-1: move to CHECK, idx=0.
  - Only a running mismatch flag is kept; entered digits are never stored.
- CHECK (1 cycle):
  - If mismatch==0: go to UNLOCKED, fail_cnt=0, timer=0.
  - Otherwise: fail_cnt+1 and fail_pulse=1 for one cycle.
    - If the new fail_cnt==MAX_TRIES: go to LOCKOUT, timer=0.
    - Otherwise: go to LOCKED.
  - mismatch is cleared in both cases.
- Latency: if edge k samples the final digit, unlocked is high after edge k+2. CHECK occupies the cycle after edge k, and the registered output updates on the following edge.
- LOCKOUT:
  - digit_valid and clear are ignored.
  - timer counts up to LOCKOUT_CYCLES-1, then the block goes to LOCKED with fail_cnt=0.
- UNLOCKED:
  - Exit to LOCKED when relock=1 or timer reaches UNLOCK_CYCLES-1.
  - A digit_valid with prog_en=1 goes to PROGRAM. That digit is the first new digit: it is shifted into shadow, idx=1, timer=0.
  - A digit_valid with prog_en=0 is ignored.
- PROGRAM:
  - Each strobe shifts a digit into the shadow register.
  - On the strobe carrying digit CODE_LEN-1: code_reg<=shadow (including that digit), then go to UNLOCKED with timer=0.
  - clear or relock aborts with code_reg unchanged: clear goes to UNLOCKED, relock goes to LOCKED.
  - The auto-relock timer does not run in PROGRAM.
- clear:
  - In ENTRY it returns to LOCKED with idx=0, mismatch=0, and no attempt is counted.
  - If clear and digit_valid arrive in the same cycle, clear wins and the digit is dropped.
  - relock has priority over clear.
- digit_valid in CHECK is ignored.
- Asserting reset mid-operation aborts everything and restores code_reg to DEFAULT_CODE. The programmed code is not retained across reset.
- Widths:
  - idx is $clog2(CODE_LEN) bits.
  - timer is $clog2(max(LOCKOUT_CYCLES,UNLOCK_CYCLES)) bits.
  - fail_cnt is 4 bits and saturates at MAX_TRIES.

Decomposition:
- Package safe_pkg:
  - state enum.
  - DIGIT_W, CODE_LEN and the default code constant.
  - A digit-select function (code, idx) returning a digit.
- One sub-module, safe_timer: a loadable up-counter with a terminal-count flag, shared by LOCKOUT and UNLOCKED.

Test Plan:
- Reset, then enter C,3,A,5 on consecutive strobes -> unlocked=1 and locked=0 two edges after the last strobe; attempts_left=3; after 500 cycles unlocked=0.
- Enter C,3,A,4 -> fail_pulse for one cycle, attempts_left=2, state LOCKED; then enter C,3,A,5 -> unlocked=1, attempts_left=3.
- Three wrong codes with LOCKOUT_CYCLES=20 -> lockout=1 for exactly 20 cycles, digits ignored throughout; afterwards attempts_left=3 and the correct code unlocks.
- Enter C,3 then clear, asserted in the same cycle as a digit strobe -> LOCKED, no fail_pulse, attempts_left unchanged; full C,3,A,5 then unlocks.
- While unlocked with prog_en=1, enter 1,2,3,4 -> UNLOCKED; relock; C,3,A,5 fails; 1,2,3,4 unlocks; drop rst_n -> C,3,A,5 unlocks again.
- rst_n dropped asynchronously mid-ENTRY and mid-LOCKOUT -> outputs return to their reset values immediately, without waiting for a clock edge.
